// File: rtl/draw_cmd_queue_pkg.sv
// Shared types for the draw command queue: command encoding, FIFO entry layout,
// register addresses and the replay FSM states.
package draw_cmd_pkg;

  typedef enum logic [1:0] {
    CMD_DRAW      = 2'd0,
    CMD_CLEAR     = 2'd1,
    CMD_FRAME_END = 2'd2,
    CMD_FLUSH     = 2'd3
  } cmd_type_t;

  typedef struct packed {
    cmd_type_t   cmd_type;
    logic [31:0] img_id;
    logic [9:0]  x;
    logic [9:0]  y;
  } cmd_entry_t;

  localparam logic [1:0] ADDR_ID_STAGE = 2'd0;
  localparam logic [1:0] ADDR_XY_STAGE = 2'd1;
  localparam logic [1:0] ADDR_CMD      = 2'd2;
  localparam logic [1:0] ADDR_STATUS   = 2'd3;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    ISSUE      = 2'd1,
    RELEASE    = 2'd2,
    WAIT_FRAME = 2'd3
  } fsm_state_t;

endpackage

// File: rtl/draw_cmd_queue_fifo.sv
// Register-based synchronous FIFO of command entries. The head entry is always
// presented on dout; a pop advances to the next entry on the following cycle.
module cmd_fifo
  import draw_cmd_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             push,
  input  cmd_entry_t       din,
  input  logic             pop,
  input  logic             flush,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count,
  output cmd_entry_t       dout
);

  localparam int PTR_W = $clog2(DEPTH);

  cmd_entry_t       mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  // A push while full is dropped even if a pop happens in the same cycle.
  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge Clk) begin
    if (Reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/draw_cmd_queue.sv
// Avalon-MM command queue that replays buffered draw/clear/frame-end commands
// to the accelerator's start/done handshake.
//   state      | meaning
//   IDLE       | pop the next command when the FIFO holds one
//   ISSUE      | start asserted, outputs held, waiting for done
//   RELEASE    | start dropped, waiting for done to return low
//   WAIT_FRAME | frame-end parked until the next frame_clk rise
module draw_cmd_queue
  import draw_cmd_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        avl_chipselect,
  input  logic [1:0]  avl_address,
  input  logic        avl_read,
  input  logic        avl_write,
  input  logic [31:0] avl_writedata,
  output logic [31:0] avl_readdata,
  output logic [31:0] img_id,
  output logic [9:0]  imgX,
  output logic [9:0]  imgY,
  output logic        draw_start,
  output logic        clear_start,
  input  logic        done,
  input  logic        frame_clk,
  output logic        busy,
  output logic        irq
);

  fsm_state_t       state, state_nxt;
  logic [31:0]      id_stage;
  logic [9:0]       x_stage, y_stage;
  logic             irq_en, overflow, frame_clk_q;
  logic [7:0]       frames_done;
  logic             wr_sel, cmd_wr, stat_wr;
  logic             fifo_push, fifo_pop, fifo_flush, fifo_full, fifo_empty;
  logic [CNT_W-1:0] fifo_count;
  logic             frame_rise, frame_tick;
  cmd_type_t        cmd_code;
  cmd_entry_t       push_entry, fifo_head;
  logic [31:0]      img_id_nxt;
  logic [9:0]       imgX_nxt, imgY_nxt;
  logic             draw_nxt, clear_nxt;
  logic [31:0]      rd_mux;

  assign wr_sel     = avl_chipselect && avl_write;
  assign cmd_wr     = wr_sel && (avl_address == ADDR_CMD);
  assign stat_wr    = wr_sel && (avl_address == ADDR_STATUS);
  assign cmd_code   = cmd_type_t'(avl_writedata[1:0]);
  assign fifo_push  = cmd_wr && (cmd_code != CMD_FLUSH);
  assign fifo_flush = cmd_wr && (cmd_code == CMD_FLUSH);
  assign frame_rise = frame_clk && !frame_clk_q;
  assign busy       = !fifo_empty || (state != IDLE);
  assign irq        = irq_en && (frames_done != 8'd0);

  always_comb begin
    push_entry          = '0;
    push_entry.cmd_type = cmd_code;
    push_entry.img_id   = id_stage;
    push_entry.x        = x_stage;
    push_entry.y        = y_stage;
  end

  cmd_fifo #(.DEPTH(DEPTH), .CNT_W(CNT_W)) u_fifo (
    .Clk   (Clk),
    .Reset (Reset),
    .push  (fifo_push),
    .din   (push_entry),
    .pop   (fifo_pop),
    .flush (fifo_flush),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count),
    .dout  (fifo_head)
  );

  always_ff @(posedge Clk) begin
    if (Reset) begin
      id_stage <= '0;
      x_stage  <= '0;
      y_stage  <= '0;
      irq_en   <= 1'b0;
    end else if (wr_sel) begin
      case (avl_address)
        ADDR_ID_STAGE: id_stage <= avl_writedata;
        ADDR_XY_STAGE: begin
          x_stage <= avl_writedata[9:0];
          y_stage <= avl_writedata[25:16];
        end
        ADDR_CMD:      irq_en <= avl_writedata[31];
        default:       ;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      overflow    <= 1'b0;
      frames_done <= 8'd0;
      frame_clk_q <= 1'b0;
    end else begin
      frame_clk_q <= frame_clk;
      if (stat_wr) begin
        overflow    <= 1'b0;
        frames_done <= 8'd0;
      end else begin
        if (fifo_push && fifo_full) overflow <= 1'b1;
        if (frame_tick && (frames_done != 8'hFF)) frames_done <= frames_done + 8'd1;
      end
    end
  end

  always_comb begin
    state_nxt  = state;
    fifo_pop   = 1'b0;
    frame_tick = 1'b0;
    img_id_nxt = img_id;
    imgX_nxt   = imgX;
    imgY_nxt   = imgY;
    draw_nxt   = draw_start;
    clear_nxt  = clear_start;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop   = 1'b1;
          img_id_nxt = fifo_head.img_id;
          imgX_nxt   = fifo_head.x;
          imgY_nxt   = fifo_head.y;
          case (fifo_head.cmd_type)
            CMD_DRAW: begin
              draw_nxt  = 1'b1;
              state_nxt = ISSUE;
            end
            CMD_CLEAR: begin
              clear_nxt = 1'b1;
              state_nxt = ISSUE;
            end
            CMD_FRAME_END: state_nxt = WAIT_FRAME;
            default:       state_nxt = IDLE;
          endcase
        end
      end
      ISSUE: begin
        if (done) begin
          draw_nxt  = 1'b0;
          clear_nxt = 1'b0;
          state_nxt = RELEASE;
        end
      end
      RELEASE: begin
        if (!done) state_nxt = IDLE;
      end
      WAIT_FRAME: begin
        if (frame_rise) begin
          frame_tick = 1'b1;
          state_nxt  = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state       <= IDLE;
      img_id      <= '0;
      imgX        <= '0;
      imgY        <= '0;
      draw_start  <= 1'b0;
      clear_start <= 1'b0;
    end else begin
      state       <= state_nxt;
      img_id      <= img_id_nxt;
      imgX        <= imgX_nxt;
      imgY        <= imgY_nxt;
      draw_start  <= draw_nxt;
      clear_start <= clear_nxt;
    end
  end

  always_comb begin
    rd_mux = '0;
    case (avl_address)
      ADDR_ID_STAGE: rd_mux = id_stage;
      ADDR_XY_STAGE: rd_mux = {6'd0, y_stage, 6'd0, x_stage};
      ADDR_STATUS: begin
        rd_mux[CNT_W-1:0] = fifo_count;
        rd_mux[16]        = fifo_empty;
        rd_mux[17]        = fifo_full;
        rd_mux[18]        = overflow;
        rd_mux[19]        = busy;
        rd_mux[31:24]     = frames_done;
      end
      default: rd_mux = '0;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) avl_readdata <= '0;
    else if (avl_chipselect && avl_read) avl_readdata <= rd_mux;
  end

endmodule

// File: tb/tb_draw_cmd_queue.sv
// Scoreboard bench for draw_cmd_queue: expected commands and read data are queued
// by the stimulus, and independent monitors compare them as the DUT presents them.
module tb_draw_cmd_queue;
  import draw_cmd_pkg::*;

  localparam int DEPTH = 16;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        avl_chipselect = 1'b0;
  logic [1:0]  avl_address = '0;
  logic        avl_read = 1'b0;
  logic        avl_write = 1'b0;
  logic [31:0] avl_writedata = '0;
  logic [31:0] avl_readdata;
  logic [31:0] img_id;
  logic [9:0]  imgX, imgY;
  logic        draw_start, clear_start;
  logic        done = 1'b0;
  logic        frame_clk = 1'b0;
  logic        busy, irq;

  always #5 Clk = ~Clk;

  draw_cmd_queue #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .Clk(Clk), .Reset(Reset), .avl_chipselect(avl_chipselect), .avl_address(avl_address),
    .avl_read(avl_read), .avl_write(avl_write), .avl_writedata(avl_writedata),
    .avl_readdata(avl_readdata), .img_id(img_id), .imgX(imgX), .imgY(imgY),
    .draw_start(draw_start), .clear_start(clear_start), .done(done),
    .frame_clk(frame_clk), .busy(busy), .irq(irq)
  );

  typedef struct {
    int          kind;
    logic [31:0] id;
    logic [9:0]  x;
    logic [9:0]  y;
  } exp_cmd_t;

  int          checks = 0;
  int          failures = 0;
  exp_cmd_t    exp_q[$];
  logic [31:0] exp_rd_q[$];
  string       rd_name_q[$];
  logic [31:0] m_id = '0, m_xy = '0;
  bit          m_irq_en = 1'b0;
  int          m_frames = 0;
  bit          resp_en = 1'b0;
  bit          fp_en = 1'b0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic logic [31:0] status_word(int cnt, bit emp, bit ful, bit ovf, bit bsy, int fr);
    logic [31:0] w;
    w = '0;
    w[CNT_W-1:0] = cnt[CNT_W-1:0];
    w[16] = emp;
    w[17] = ful;
    w[18] = ovf;
    w[19] = bsy;
    w[31:24] = fr[7:0];
    return w;
  endfunction

  task automatic avl_wr(logic [1:0] a, logic [31:0] d, bit cs = 1'b1);
    avl_chipselect = cs; avl_write = 1'b1; avl_address = a; avl_writedata = d;
    @(negedge Clk);
    avl_chipselect = 1'b0; avl_write = 1'b0;
    if (cs) begin
      case (a)
        ADDR_ID_STAGE: m_id = d;
        ADDR_XY_STAGE: m_xy = d & 32'h03FF_03FF;
        ADDR_CMD:      m_irq_en = d[31];
        default:       m_frames = 0;
      endcase
    end
  endtask

  task automatic avl_rd(logic [1:0] a, logic [31:0] expv, string name);
    exp_rd_q.push_back(expv);
    rd_name_q.push_back(name);
    avl_chipselect = 1'b1; avl_read = 1'b1; avl_address = a;
    @(negedge Clk);
    avl_chipselect = 1'b0; avl_read = 1'b0;
  endtask

  task automatic post_cmd(int kind, logic [31:0] id, logic [31:0] xy, bit irqen, bit accept);
    exp_cmd_t e;
    avl_wr(ADDR_ID_STAGE, id);
    avl_wr(ADDR_XY_STAGE, xy);
    if (accept && kind < 2) begin
      e.kind = kind; e.id = id; e.x = xy[9:0]; e.y = xy[25:16];
      exp_q.push_back(e);
    end
    avl_wr(ADDR_CMD, {irqen, 29'd0, 2'(kind)});
  endtask

  task automatic wait_start(int budget, string name);
    int n = 0;
    while (!draw_start && !clear_start && n < budget) begin
      @(negedge Clk);
      n++;
    end
    chk(name, draw_start | clear_start, 1'b1);
  endtask

  task automatic wait_idle(int budget, string name);
    int n = 0;
    while (busy && n < budget) begin
      @(negedge Clk);
      n++;
    end
    chk(name, busy, 1'b0);
  endtask

  task automatic pulse_frame();
    frame_clk = 1'b1;
    @(negedge Clk);
    frame_clk = 1'b0;
  endtask

  // read-data monitor
  initial begin
    bit fire;
    forever begin
      @(posedge Clk);
      fire = avl_read && avl_chipselect;
      @(negedge Clk);
      if (fire) begin
        if (exp_rd_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_read actual=%0h required=none", avl_readdata);
        end else begin
          chk(rd_name_q.pop_front(), avl_readdata, exp_rd_q.pop_front());
        end
      end
    end
  end

  // command monitor
  initial begin
    bit pd, pc;
    exp_cmd_t e;
    pd = 1'b0; pc = 1'b0;
    forever begin
      @(negedge Clk);
      if ((draw_start && !pd) || (clear_start && !pc)) begin
        chk("start_exclusive", draw_start & clear_start, 1'b0);
        chk("start_with_done_low", done, 1'b0);
        if (exp_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_start actual=draw%0b/clear%0b id=%0h required=no_start",
                   draw_start, clear_start, img_id);
        end else begin
          e = exp_q.pop_front();
          chk("cmd_kind", {clear_start, draw_start}, (e.kind == 1) ? 2'b10 : 2'b01);
          chk("cmd_img_id", img_id, e.id);
          chk("cmd_x", imgX, e.x);
          chk("cmd_y", imgY, e.y);
        end
      end
      pd = draw_start; pc = clear_start;
    end
  end

  // accelerator model
  initial begin
    logic [31:0] cid;
    logic [9:0]  cx, cy;
    bit          cdraw;
    forever begin
      @(negedge Clk);
      if (resp_en && !Reset && (draw_start || clear_start)) begin
        cid = img_id; cx = imgX; cy = imgY; cdraw = draw_start;
        repeat ($urandom_range(1, 3)) @(negedge Clk);
        chk("hold_stable", {img_id, imgX, imgY, draw_start, clear_start}, {cid, cx, cy, cdraw, !cdraw});
        done = 1'b1;
        @(negedge Clk);
        chk("start_fall", draw_start | clear_start, 1'b0);
        repeat ($urandom_range(0, 2)) @(negedge Clk);
        done = 1'b0;
      end
    end
  end

  // free-running frame ticks for the random phase
  initial begin
    forever begin
      @(negedge Clk);
      if (fp_en) begin
        repeat ($urandom_range(2, 8)) @(negedge Clk);
        frame_clk = 1'b1;
        @(negedge Clk);
        frame_clk = 1'b0;
      end
    end
  end

  initial begin
    #1000000;
    failures++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n, nf, kind;
    logic [31:0] id, xy;
    bit ie;

    repeat (3) @(negedge Clk);
    chk("reset_starts", {draw_start, clear_start, busy, irq}, 4'b0);
    chk("reset_cmd_out", {img_id, imgX, imgY}, 52'd0);
    chk("reset_readdata", avl_readdata, 32'd0);
    Reset = 1'b0;
    @(negedge Clk);
    avl_rd(ADDR_STATUS, status_word(0, 1, 0, 0, 0, 0), "reset_status");
    avl_rd(ADDR_ID_STAGE, 32'd0, "reset_id_stage");

    // single draw with a hand-driven done
    post_cmd(0, 32'h5, 32'h0032_0064, 1'b0, 1'b1);
    wait_start(10, "t1_draw_start");
    repeat (2) @(negedge Clk);
    done = 1'b1;
    @(negedge Clk);
    chk("t1_start_fall", draw_start, 1'b0);
    post_cmd(0, 32'hA5A5_0001, 32'h0123_0321, 1'b0, 1'b1);
    repeat (2) @(negedge Clk);
    chk("t1_hold_off_while_done", draw_start, 1'b0);
    done = 1'b0;
    wait_start(10, "t1_second_start");
    @(negedge Clk);
    done = 1'b1;
    @(negedge Clk);
    done = 1'b0;
    wait_idle(20, "t1_idle");

    // clear, frame-end, draw: draw parks until frame_clk
    resp_en = 1'b1;
    avl_wr(ADDR_STATUS, 32'd0);
    post_cmd(1, 32'h0000_0C1E, 32'h0011_0022, 1'b0, 1'b1);
    post_cmd(2, 32'h0, 32'h0, 1'b0, 1'b1);
    post_cmd(0, 32'h0000_0D0D, 32'h0200_0100, 1'b0, 1'b1);
    repeat (20) @(negedge Clk);
    chk("t2_parked_no_draw", draw_start, 1'b0);
    avl_rd(ADDR_STATUS, status_word(1, 0, 0, 0, 1, 0), "t2_parked_status");
    pulse_frame();
    m_frames = 1;
    n = 0;
    while (!draw_start && n < 2) begin
      @(negedge Clk);
      n++;
    end
    chk("t2_draw_after_frame", draw_start, 1'b1);
    wait_idle(50, "t2_idle");
    avl_rd(ADDR_STATUS, status_word(0, 1, 0, 0, 0, m_frames), "t2_frames_done");

    // overflow
    resp_en = 1'b0;
    for (int i = 0; i < DEPTH + 2; i++)
      post_cmd(0, 32'h100 + i, 32'h0005_0007 + i, 1'b0, (i < DEPTH + 1));
    avl_rd(ADDR_STATUS, status_word(DEPTH, 0, 1, 1, 1, m_frames), "t3_full_overflow");
    avl_wr(ADDR_STATUS, $urandom);
    avl_rd(ADDR_STATUS, status_word(DEPTH, 0, 1, 0, 1, 0), "t3_overflow_cleared");
    resp_en = 1'b1;
    wait_idle(1000, "t3_drain");
    chk("t3_all_issued", exp_q.size(), 0);

    // flush with a draw in flight
    resp_en = 1'b0;
    post_cmd(0, 32'hF1, 32'h0001_0001, 1'b0, 1'b1);
    post_cmd(0, 32'hF2, 32'h0002_0002, 1'b0, 1'b0);
    post_cmd(0, 32'hF3, 32'h0003_0003, 1'b0, 1'b0);
    chk("t4_in_flight", draw_start, 1'b1);
    avl_wr(ADDR_CMD, 32'h0000_0003);
    avl_rd(ADDR_STATUS, status_word(0, 1, 0, 0, 1, 0), "t4_flushed");
    resp_en = 1'b1;
    wait_idle(50, "t4_idle");
    repeat (10) @(negedge Clk);
    avl_rd(ADDR_STATUS, status_word(0, 1, 0, 0, 0, 0), "t4_status_after");

    // reset while issuing
    resp_en = 1'b0;
    post_cmd(0, 32'hE1, 32'h0009_0009, 1'b0, 1'b1);
    post_cmd(1, 32'hE2, 32'h0008_0008, 1'b0, 1'b0);
    post_cmd(0, 32'hE3, 32'h0007_0007, 1'b0, 1'b0);
    chk("t5_issuing", draw_start, 1'b1);
    Reset = 1'b1;
    @(negedge Clk);
    chk("t5_start_dropped", {draw_start, clear_start}, 2'b00);
    chk("t5_busy_cleared", busy, 1'b0);
    Reset = 1'b0;
    m_id = '0; m_xy = '0; m_irq_en = 1'b0; m_frames = 0;
    exp_q.delete();
    @(negedge Clk);
    avl_rd(ADDR_STATUS, status_word(0, 1, 0, 0, 0, 0), "t5_status");
    avl_rd(ADDR_XY_STAGE, m_xy, "t5_xy_stage");
    resp_en = 1'b1;
    repeat (10) @(negedge Clk);
    chk("t5_stays_idle", busy, 1'b0);
    avl_wr(ADDR_ID_STAGE, 32'hDEAD_BEEF, 1'b0);
    avl_rd(ADDR_ID_STAGE, m_id, "t5_unselected_write");

    // frames_done saturation and irq
    for (int i = 0; i < 256; i++) begin
      avl_wr(ADDR_CMD, 32'h8000_0002);
      @(negedge Clk);
      pulse_frame();
      if (m_frames < 255) m_frames++;
      if (i == 0) chk("t6_irq_first", irq, 1'b1);
    end
    avl_rd(ADDR_STATUS, status_word(0, 1, 0, 0, 0, m_frames), "t6_saturated");
    chk("t6_irq_set", irq, 1'b1);
    avl_wr(ADDR_STATUS, 32'd0);
    chk("t6_irq_cleared", irq, 1'b0);
    avl_rd(ADDR_STATUS, status_word(0, 1, 0, 0, 0, 0), "t6_frames_cleared");

    // random bursts against the queue model
    fp_en = 1'b1;
    for (int b = 0; b < 6; b++) begin
      avl_wr(ADDR_STATUS, 32'd0);
      n = $urandom_range(1, DEPTH);
      nf = 0;
      for (int i = 0; i < n; i++) begin
        kind = $urandom_range(0, 2);
        id = $urandom;
        xy = $urandom;
        ie = 1'($urandom_range(0, 1));
        if (kind == 2) nf++;
        post_cmd(kind, id, xy, ie, 1'b1);
        if ($urandom_range(0, 3) == 0) begin
          avl_rd(ADDR_XY_STAGE, m_xy, "rand_xy_readback");
          avl_rd(ADDR_ID_STAGE, m_id, "rand_id_readback");
        end
        repeat ($urandom_range(0, 2)) @(negedge Clk);
      end
      wait_idle(2000, "rand_idle");
      avl_rd(ADDR_STATUS, status_word(0, 1, 0, 0, 0, (nf > 255) ? 255 : nf), "rand_status");
      chk("rand_irq", irq, m_irq_en && (nf > 0));
    end
    fp_en = 1'b0;
    repeat (12) @(negedge Clk);

    chk("exp_queue_drained", exp_q.size(), 0);
    chk("read_queue_drained", exp_rd_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/draw_cmd_queue.md
Name: draw_cmd_queue

Overview:
- Avalon-MM slave that buffers software draw/clear/frame-end commands in a FIFO.
- Replays the commands one at a time to the graphics accelerator's software interface (img_id, imgX, imgY, draw_start, clear_start, done).
- Sits directly upstream of the accelerator, so the NIOS can post a whole frame's sprite list without polling done per sprite.
- Frame-end commands stall the queue until the next frame_clk rising edge, which paces rendering to the display.

Parameters:
- DEPTH, 16, FIFO entries; power of two, minimum 2.
- CNT_W, $clog2(DEPTH)+1, occupancy counter width.

Ports:
- Clk  in  1  system clock
- Reset  in  1  synchronous, active-high
- avl_chipselect  in  1  slave select
- avl_address  in  2  register index
- avl_read  in  1  read strobe
- avl_write  in  1  write strobe
- avl_writedata  in  32  write data
- avl_readdata  out  32  read data, registered
- img_id  out  32  image ID to the accelerator
- imgX  out  10  X coordinate to the accelerator
- imgY  out  10  Y coordinate to the accelerator
- draw_start  out  1  draw request
- clear_start  out  1  clear request
- done  in  1  accelerator completion, level
- frame_clk  in  1  frame tick from the accelerator, Clk domain
- busy  out  1  high when the FIFO is non-empty or the FSM is not IDLE
- irq  out  1  level; asserts when frames_done != 0 and IRQ_EN is set

Behaviour:
- Register map (writes take effect only with chipselect high):
  - addr 0 ID_STAGE (R/W): staging img_id.
  - addr 1 XY_STAGE (R/W): imgX = [9:0], imgY = [25:16], other bits read 0.
  - addr 2 CMD (W): [1:0] = 0 draw, 1 clear, 2 frame_end, 3 flush. Types 0-2 push {type, ID_STAGE, XY_STAGE} onto the FIFO. Flush empties the FIFO but does not abort the in-flight command. [31] = IRQ_EN, written on every CMD write.
  - addr 3 STATUS:
    - Read: [CNT_W-1:0] = count, [16] = empty, [17] = full, [18] = overflow, [19] = busy, [31:24] = frames_done.
    - Write of any value clears overflow and frames_done.
- Read latency: 1 cycle. avl_readdata is registered from the address sampled with avl_read. Reading is side-effect free.
- Push when full: entry dropped, sticky overflow set, count unchanged.
- Simultaneous push and pop: both performed, count unchanged. A push into an empty FIFO is poppable the following cycle; there is no fall-through.
- Flush in the same cycle as a push: flush wins and the pushed entry is discarded.
- FSM states and transitions:
  - IDLE: if FIFO not empty, pop. Latch the entry into the output registers.
    - type draw → ISSUE, draw_start = 1.
    - type clear → ISSUE, clear_start = 1.
    - type frame_end → WAIT_FRAME.
  - ISSUE: hold the start signal and the outputs stable until done == 1. Then deassert the start signal and go to RELEASE.
  - RELEASE: wait for done == 0, then go to IDLE. This guarantees the accelerator has returned to idle before the next start.
  - WAIT_FRAME: edge-detect frame_clk using one register, frame_clk_q. On frame_clk & ~frame_clk_q: frames_done saturating-increment (max 255), go to IDLE.
- Minimum command spacing: IDLE→ISSUE→RELEASE→IDLE is at least 3 cycles per draw.
- draw_start and clear_start are never high together.
- Reset values:
  - All outputs 0.
  - FSM in IDLE; FIFO empty; pointers, count, overflow and frames_done all 0.
  - IRQ_EN 0; staging registers 0; frame_clk_q 0.
- Reset mid-operation: start signals drop the next cycle. The queued and in-flight commands are discarded, and the in-flight command is not re-issued.

Decomposition:
- Package draw_cmd_pkg:
  - cmd_type_t enum {CMD_DRAW, CMD_CLEAR, CMD_FRAME_END, CMD_FLUSH}.
  - Packed struct cmd_entry_t {type, img_id[31:0], x[9:0], y[9:0]}.
  - Register address localparams.
  - fsm_state_t enum {IDLE, ISSUE, RELEASE, WAIT_FRAME}.
- Sub-module cmd_fifo:
  - Synchronous FIFO of cmd_entry_t, parameter DEPTH.
  - Ports: push, pop, flush, full, empty, count, dout.
  - Register-based storage, 1-cycle pop-to-dout.

Test Plan:
- Write ID=0x5, XY=0x0032_0064, CMD=0 → next IDLE pops; draw_start=1 with img_id=5, imgX=100, imgY=50. Drive done=1 two cycles later → draw_start=0 the next cycle; no new start until done=0.
- Push CMD=1, then CMD=2, then CMD=0 with no frame_clk → clear issued and completed; FSM parks in WAIT_FRAME with draw_start=0. Pulse frame_clk high → frames_done=1 and the draw issues within 2 cycles.
- Push DEPTH+2 draws with done held 0 → STATUS full=1, count=DEPTH, overflow=1. Write STATUS → overflow=0, count unchanged.
- Push 3 draws, hold done=0 so the first is in flight, write CMD=3 → count=0. The in-flight draw completes on done; no further starts.
- Assert Reset during ISSUE with draw_start=1 → next cycle draw_start=0, busy=0, STATUS reads 0 (empty bit=1).
- IRQ_EN=1 with 256 frame_end commands, each released by one frame_clk pulse → frames_done saturates at 255, irq=1. Write STATUS → frames_done=0 and irq=0 on the next cycle.
